isp_dram_reader: RTL and testbench
==================================

Name: isp_dram_reader

Overview:
AXI4 read master that fetches one full 32x32 RGB picture (3072 bytes, 192 beats of 128 bits) from pseudo_DRAM on request. It sits directly upstream of the ISP processing core, which sees the picture as a ready/valid beat stream. It owns the ISP read address and read data channels.

Parameters:
BASE_ADDR, 32'h0001_0000, DRAM byte address of picture 0
PIC_BYTES, 3072, bytes per picture (address stride)
BEATS, 192, beats per picture; arlen = BEATS-1
AXI_ID, 4'd0, constant arid; rid is expected to match it

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  fetch request
req_pic_no  in  4  picture number, 0..15
req_ready  out  1  high only in IDLE
arid_s_inf  out  4  = AXI_ID
araddr_s_inf  out  32  burst start address
arlen_s_inf  out  8  = BEATS-1 (191)
arsize_s_inf  out  3  = 3'b100 (16 bytes)
arburst_s_inf  out  2  = 2'b01 (INCR)
arvalid_s_inf  out  1  address valid
arready_s_inf  in  1  address ready
rid_s_inf  in  4  read id
rdata_s_inf  in  128  read data
rresp_s_inf  in  2  read response
rlast_s_inf  in  1  last beat
rvalid_s_inf  in  1  data valid
rready_s_inf  out  1  data ready
pix_valid  out  1  beat available to core
pix_ready  in  1  core accepts beat
pix_data  out  128  beat payload; byte 0 at [7:0]
pix_idx  out  8  beat index, 0..191
pix_last  out  1  high with beat 191
busy  out  1  high in any state other than IDLE
err  out  1  sticky protocol/response error

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: FSM=IDLE, arvalid=0, rready=0, FIFO empty, pix_valid=0, pix_idx=0, pix_last=0, busy=0, err=0, beat counter=0. The static AXI fields (id, len, size, burst) are constant at all times.
- FSM states: IDLE, ADDR, DATA, DRAIN.
- IDLE: req_ready=1. On req_valid, latch pic_no, clear err, and go to ADDR on the next cycle.
- ADDR: arvalid=1, araddr = BASE_ADDR + pic_no*PIC_BYTES. araddr is registered and stable while arvalid is high. On arvalid&arready, drop arvalid on the next edge and go to DATA.
- DATA: rready = (fifo_count < 2). Each rvalid&rready beat is pushed into the 2-entry FIFO, tagged with beat counter value k and last = (k==191); then k increments.
  - After beat 191 is accepted: go to DRAIN and drop rready on the next edge.
- DRAIN: wait until the FIFO is empty and the final pop has completed, then go to IDLE. No new request is accepted until IDLE.
- Output FIFO:
  - Depth 2, registered outputs. pix_valid = !empty; pix_data/pix_idx/pix_last come from the head entry.
  - Pop on pix_valid&pix_ready.
  - Simultaneous push and pop at count 1 keeps count 1.
  - Push is impossible at count 2, because rready is 0.
  - A held head must keep pix_* stable while pix_ready=0.
  - Latency: an rdata beat accepted at edge N appears on pix_data after edge N when the FIFO was empty (1 cycle).
- Error detection: err is set, and stays set until the next accepted request, on any of:
  - rresp != 2'b00 on an accepted beat;
  - rid != AXI_ID;
  - rlast=1 on a beat with k != 191;
  - rlast=0 on beat 191.
  The burst still completes by beat count (192 beats). rlast is not used for termination.
- Ignored inputs: req_valid while busy is ignored. rvalid outside DATA is ignored, and rready stays 0 there.
- Reset mid-operation: return to IDLE immediately with arvalid/rready low and the FIFO flushed. The system resets pseudo_DRAM concurrently; no transaction is resumed.

Test Plan:
- Pic 0, zero-wait DRAM, pix_ready=1 -> araddr=0x0001_0000, arlen=191, arsize=4, arburst=1; 192 pix beats with idx 0..191 in order; pix_last only on idx 191; busy falls 1 cycle after last pop.
- Pic 15 and pic 3 -> araddr=0x0001_B400 and 0x0001_2400 respectively; data matches DRAM contents at those addresses, byte-exact.
- arready delayed 7 cycles -> arvalid held 8 cycles with araddr stable; exactly one address handshake.
- pix_ready held low for 20 cycles mid-burst -> FIFO fills to 2; rready=0 within 1 cycle; no beat lost or duplicated; pix_data stable while stalled.
- rresp=2'b10 on beat 50 / rlast early on beat 100 -> err=1 from the following cycle; all 192 beats still delivered; err cleared on the next req_valid.
- rst=1 asserted at beat 80 -> next edge gives arvalid=0, rready=0, pix_valid=0, busy=0; a new request for pic 2 then completes normally at araddr 0x0001_1800.

Source files
------------

// File: rtl/isp_dram_reader.sv
// AXI4 read master: fetches one 32x32 RGB picture as a single INCR burst and
// hands it to the ISP core as a ready/valid beat stream through a 2-deep FIFO.
module isp_dram_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned PIC_BYTES = 3072,
  parameter int unsigned BEATS     = 192,
  parameter logic [3:0]  AXI_ID    = 4'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [3:0]   req_pic_no,
  output logic         req_ready,
  output logic [3:0]   arid_s_inf,
  output logic [31:0]  araddr_s_inf,
  output logic [7:0]   arlen_s_inf,
  output logic [2:0]   arsize_s_inf,
  output logic [1:0]   arburst_s_inf,
  output logic         arvalid_s_inf,
  input  logic         arready_s_inf,
  input  logic [3:0]   rid_s_inf,
  input  logic [127:0] rdata_s_inf,
  input  logic [1:0]   rresp_s_inf,
  input  logic         rlast_s_inf,
  input  logic         rvalid_s_inf,
  output logic         rready_s_inf,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic [127:0] pix_data,
  output logic [7:0]   pix_idx,
  output logic         pix_last,
  output logic         busy,
  output logic         err
);
  localparam logic [7:0] LAST_K = 8'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   idx;
    logic         last;
  } beat_t;

  state_t      state, state_nx;
  logic [7:0]  k;
  beat_t       fifo [2];
  beat_t       head;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        req_acc, push, pop, beat_bad;

  assign arid_s_inf    = AXI_ID;
  assign arlen_s_inf   = LAST_K;
  assign arsize_s_inf  = 3'b100;
  assign arburst_s_inf = 2'b01;

  assign head      = fifo[rd_ptr];
  assign pix_data  = head.data;
  assign pix_idx   = head.idx;
  assign pix_last  = head.last;
  assign pix_valid = (count != 2'd0);

  assign req_acc = req_valid && req_ready;
  assign push    = rvalid_s_inf && rready_s_inf;
  assign pop     = pix_valid && pix_ready;
  // rlast must agree with the beat count; termination itself ignores rlast
  assign beat_bad = (rresp_s_inf != 2'b00) || (rid_s_inf != AXI_ID) ||
                    (rlast_s_inf != (k == LAST_K));

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    arvalid_s_inf = 1'b0;
    rready_s_inf  = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = ADDR;
      end
      ADDR: begin
        arvalid_s_inf = 1'b1;
        if (arready_s_inf) state_nx = DATA;
      end
      DATA: begin
        rready_s_inf = (count < 2'd2);
        if (push && k == LAST_K) state_nx = DRAIN;
      end
      DRAIN: if (count == 2'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      araddr_s_inf <= BASE_ADDR;
      k            <= '0;
      err          <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else begin
      state <= state_nx;
      if (req_acc) begin
        araddr_s_inf <= BASE_ADDR + 32'(req_pic_no) * PIC_BYTES;
        k            <= '0;
        err          <= 1'b0;
      end
      if (push) begin
        fifo[wr_ptr] <= '{data: rdata_s_inf, idx: k, last: (k == LAST_K)};
        wr_ptr       <= ~wr_ptr;
        k            <= k + 8'd1;
        if (beat_bad) err <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_isp_dram_reader.sv
// Bench for isp_dram_reader: a behavioural DRAM slave feeds bursts, expected
// beats go into a scoreboard queue that an independent monitor drains.
module tb_isp_dram_reader;
  logic         clk = 1'b0, rst;
  logic         req_valid, req_ready;
  logic [3:0]   req_pic_no;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;
  logic         pix_valid, pix_ready, pix_last, busy, err;
  logic [127:0] pix_data;
  logic [7:0]   pix_idx;

  isp_dram_reader dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pic_no(req_pic_no), .req_ready(req_ready),
    .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen), .arsize_s_inf(arsize),
    .arburst_s_inf(arburst), .arvalid_s_inf(arvalid), .arready_s_inf(arready),
    .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp), .rlast_s_inf(rlast),
    .rvalid_s_inf(rvalid), .rready_s_inf(rready),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_idx(pix_idx),
    .pix_last(pix_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   idx;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0;
  int cyc = 0, popped = 0, last_pop_edge = 0;
  bit done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // DRAM content: each byte derived from its own byte address
  function automatic logic [127:0] beat_at(input logic [31:0] a);
    logic [31:0] b;
    beat_at = '0;
    for (int i = 0; i < 16; i++) begin
      b = a + 32'(i);
      beat_at[8*i +: 8] = b[7:0] ^ {b[11:8], b[15:12]} ^ b[23:16];
    end
  endfunction

  task automatic chki(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic die(input string name);
    fails++;
    $display("FAIL %s: timed out", name);
    $fatal(1, "bench stopped: %s", name);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && pix_valid && pix_ready) begin
      if (sb.size() == 0) chki("pop_unexpected", int'(pix_idx), -1);
      else begin
        e = sb.pop_front();
        chkd("pix_data", pix_data, e.data);
        chki("pix_idx", int'(pix_idx), int'(e.idx));
        chki("pix_last", int'(pix_last), int'(e.last));
      end
      popped++;
      last_pop_edge = cyc + 1;
    end
  end

  task automatic do_req(input logic [3:0] pic);
    int to = 0;
    while (!req_ready) begin
      @(posedge clk); #1;
      if (++to > 300) die("req_ready_wait");
    end
    req_valid = 1'b1; req_pic_no = pic;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chki("busy_after_req", int'(busy), 1);
    chki("err_cleared", int'(err), 0);
  endtask

  task automatic drive_beat(input logic [31:0] a, input int k, input bit bresp, input bit blast);
    rvalid = 1'b1;
    rdata  = beat_at(a + 32'(16 * k));
    rid    = 4'd0;
    rresp  = bresp ? 2'b10 : 2'b00;
    rlast  = (k == 191) || blast;
  endtask

  task automatic serve(input logic [31:0] exp_addr, input int ar_delay, input int bad_beat,
                       input int bad_kind, input int rst_beat, input bit poke_req);
    int n = 0, to = 0, k = 0, ar_bad = 0;
    bit hs;
    logic [31:0] a;
    chki("arlen", int'(arlen), 191);
    chki("arsize", int'(arsize), 4);
    chki("arburst", int'(arburst), 1);
    chki("arid", int'(arid), 0);
    forever begin
      if (arvalid) begin
        n++;
        if (araddr !== exp_addr) ar_bad++;
        if (n > ar_delay) break;
      end else begin
        if (n > 0) ar_bad++;
        if (++to > 100) die("arvalid_wait");
      end
      @(posedge clk); #1;
    end
    a = araddr; arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chki("arvalid_drop", int'(arvalid), 0);
    chki("araddr", int'(a), int'(exp_addr));
    chki("araddr_stable", ar_bad, 0);
    if (poke_req) begin req_valid = 1'b1; req_pic_no = 4'd9; end
    to = 0;
    drive_beat(a, 0, bad_kind == 1 && bad_beat == 0, bad_kind == 2 && bad_beat == 0);
    while (k < 192) begin
      hs = rready;
      if (arvalid) ar_bad++;
      @(posedge clk); #1;
      if (hs) begin
        sb.push_back('{beat_at(exp_addr + 32'(16 * k)), 8'(k), 1'(k == 191)});
        if (k == bad_beat) chki("err_set", int'(err), 1);
        else if (k == bad_beat - 1) chki("err_before", int'(err), 0);
        k++; to = 0;
        if (k == rst_beat) begin
          rvalid = 1'b0; rst = 1'b1; req_valid = 1'b0;
          @(posedge clk); #1;
          chki("rst_arvalid", int'(arvalid), 0);
          chki("rst_rready", int'(rready), 0);
          chki("rst_pix_valid", int'(pix_valid), 0);
          chki("rst_busy", int'(busy), 0);
          rst = 1'b0;
          sb.delete();
          popped = 0;
          return;
        end
        if (k < 192) drive_beat(a, k, bad_kind == 1 && bad_beat == k, bad_kind == 2 && bad_beat == k);
        else rvalid = 1'b0;
      end else if (++to > 100) die("rready_wait");
    end
    req_valid = 1'b0;
    chki("single_ar", ar_bad, 0);
  endtask

  task automatic pix_drv(input int stall_at);
    logic [127:0] d;
    logic [7:0]   ix;
    int bad;
    pix_ready = 1'b1;
    while (!done) begin
      @(posedge clk); #1;
      if (stall_at >= 0 && popped == stall_at && !done) begin
        pix_ready = 1'b0; d = pix_data; ix = pix_idx; bad = 0;
        repeat (20) begin
          @(posedge clk); #1;
          if (pix_data !== d || pix_idx !== ix) bad++;
        end
        chki("stall_stable", bad, 0);
        chki("stall_rready", int'(rready), 0);
        chki("stall_pix_valid", int'(pix_valid), 1);
        pix_ready = 1'b1;
        stall_at = -1;
      end
    end
  endtask

  task automatic run(input logic [3:0] pic, input logic [31:0] exp_addr, input int ar_delay,
                     input int bad_beat, input int bad_kind, input int stall_at,
                     input int rst_beat, input bit poke, input bit exp_err);
    int to = 0;
    popped = 0; sb.delete(); done = 1'b0;
    do_req(pic);
    fork
      begin serve(exp_addr, ar_delay, bad_beat, bad_kind, rst_beat, poke); done = 1'b1; end
      pix_drv(stall_at);
    join
    if (rst_beat >= 0) return;
    while (busy) begin
      @(posedge clk); #1;
      if (++to > 100) die("drain_wait");
    end
    chki("busy_fall_cycle", cyc, last_pop_edge + 1);
    chki("beat_count", popped, 192);
    chki("sb_empty", sb.size(), 0);
    chki("err_final", int'(err), int'(exp_err));
  endtask

  initial begin
    #5_000_000;
    die("watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_pic_no = '0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chki("reset_arvalid", int'(arvalid), 0);
    chki("reset_rready", int'(rready), 0);
    chki("reset_pix_valid", int'(pix_valid), 0);
    chki("reset_pix_idx", int'(pix_idx), 0);
    chki("reset_pix_last", int'(pix_last), 0);
    chki("reset_busy", int'(busy), 0);
    chki("reset_err", int'(err), 0);
    chki("reset_req_ready", int'(req_ready), 1);
    //  pic  address         ardly bad  kind stall rst  poke err
    run(4'd0,  32'h0001_0000, 0,  -1,  0,  -1,  -1,  0,   0);
    run(4'd15, 32'h0001_B400, 0,  -1,  0,  -1,  -1,  0,   0);
    run(4'd3,  32'h0001_2400, 7,  -1,  0,  -1,  -1,  1,   0);
    run(4'd1,  32'h0001_0C00, 0,  -1,  0,  60,  -1,  0,   0);
    run(4'd4,  32'h0001_3000, 0,  50,  1,  -1,  -1,  0,   1);
    run(4'd5,  32'h0001_3C00, 0,  100, 2,  -1,  -1,  0,   1);
    run(4'd6,  32'h0001_4800, 0,  -1,  0,  -1,  80,  0,   0);
    run(4'd2,  32'h0001_1800, 0,  -1,  0,  -1,  -1,  0,   0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
